regfile_write_bank: RTL and testbench
=====================================

// Module: regfile_write_bank
// PURPOSE
//  - Write side of the 32x32 register file: 5-to-32 write decode, 32 storage registers, bulk-clear sequencer.
//  - Exposes every register on a flat bus that drives the 32 data inputs of the register-file read mux.
//  - Writeback stage pushes writes over a valid/ready handshake.
//  - The control unit requests a full-file clear that walks one register per cycle.
// PARAMETERS
//  NREG   32   number of registers (fixed; address width AW = 5)
//  DW     32   register data width
// PORTS
//  clk        in   1        system clock, all state on rising edge
//  rst        in   1        synchronous active-high reset
//  wr_valid   in   1        write request valid
//  wr_ready   out  1        bank can accept a write this cycle
//  wr_addr    in   5        destination register index
//  wr_data    in   DW       write data
//  clr_req    in   1        request clear of all registers (level, sampled in IDLE)
//  clr_busy   out  1        clear sequence in progress
//  clr_done   out  1        one-cycle pulse on the final clear cycle
//  q_all      out  NREG*DW  q_all[DW*i +: DW] = register i
// BEHAVIOUR
//  - Reset (rst=1 at posedge): all registers <= 0, state <= IDLE, clr_cnt <= 0.
//    Outputs on the following cycle: q_all=0, wr_ready=1, clr_busy=0, clr_done=0.
//  - FSM states are IDLE and CLEAR.
//    IDLE: wr_ready=1.
//    CLEAR: wr_ready=0, clr_busy=1.
//  - Write: accepted when wr_valid & wr_ready at a posedge.
//    reg[wr_addr] <= wr_data.
//    Visible on q_all the next cycle (latency 1, no read bypass).
//  - IDLE -> CLEAR when clr_req=1 at a posedge; clr_cnt <= 0 on that edge.
//  - CLEAR: each cycle reg[clr_cnt] <= 0 and clr_cnt++.
//    When clr_cnt==31: clr_done=1 (combinational in that cycle), next state is IDLE.
//    Total 32 cycles in CLEAR.
//  - Simultaneous wr_valid and clr_req in IDLE: the write is accepted and performed, then CLEAR begins.
//    The written register is zeroed when the counter reaches it.
//  - clr_req while in CLEAR is ignored; no restart.
//  - wr_valid while in CLEAR is not accepted; the writer holds wr_addr/wr_data stable until wr_ready.
//  - clr_cnt wraps 31 -> 0 only via the CLEAR -> IDLE exit; it is never read in IDLE.
//  - rst mid-CLEAR: immediate return to IDLE with all registers 0; clr_done is not pulsed.
//  - Unselected registers hold their value every cycle.
// CONFIGURATION
//  REG0_HARDWIRE_EN
//   defined:   register 0 is constant zero. Writes with wr_addr==0 are handshaken (wr_ready=1) and discarded.
//              q_all[DW-1:0] is always 0.
//   undefined: register 0 is an ordinary storage register, written and cleared like the others.
// STRUCTURE
//  - Package regfile_pkg:
//    - localparams NREG=32, AW=5, DW=32.
//    - typedef enum logic {ST_IDLE, ST_CLEAR} wb_state_t.
//    - typedef logic [AW-1:0] reg_idx_t.
//  - Sub-module decoder5_to_32: 5-bit index + enable -> 32-bit one-hot row select.
//    Used for both the write select and the clear select (muxed by state).
// TESTING
//  1. Reset, then write addr=5 data=32'hDEADBEEF
//     -> next cycle q_all[5] = DEADBEEF; all other registers 0.
//  2. Write addr=31 data=32'h1234_5678, then addr=0 data=32'hFFFF_FFFF
//     -> reg31 = 12345678; reg0 = 0 with REG0_HARDWIRE_EN, FFFFFFFF without.
//  3. Fill all 32 registers with data=i+1, pulse clr_req
//     -> clr_busy high 32 cycles, wr_ready low, reg[k] = 0 after cycle k;
//        clr_done pulses once on cycle 32; then IDLE with wr_ready=1.
//  4. wr_valid addr=7 data=32'hA5A5A5A5 and clr_req in the same IDLE cycle
//     -> reg7 = A5A5A5A5 for cycles until counter reaches 7, then 0.
//  5. wr_valid held during CLEAR with addr=3 data=32'h55
//     -> not accepted until IDLE; reg3 = 55 one cycle after clr_done.
//  6. Assert rst at clear cycle 10 with registers preloaded
//     -> all registers 0, clr_busy=0, no clr_done pulse, wr_ready=1 after reset.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and sizes for the register-file write bank.
package regfile_pkg;

  localparam int unsigned NREG = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned DW   = 32;

  typedef enum logic {ST_IDLE, ST_CLEAR} wb_state_t;

  typedef logic [AW-1:0] reg_idx_t;

endpackage

// File: rtl/decoder5_to_32.sv
// 5-bit index plus enable to 32-bit one-hot row select.
module decoder5_to_32
  import regfile_pkg::*;
(
  input  reg_idx_t         idx_i,
  input  logic             en_i,
  output logic [NREG-1:0]  onehot_o
);

  // Single row asserted when enabled, none otherwise.
  always_comb begin
    onehot_o = '0;
    if (en_i) begin
      onehot_o[idx_i] = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_write_bank.sv
// Write side of the 32x32 register file: write decode, storage and a
// one-register-per-cycle bulk-clear sequencer. All registers are exposed on
// q_all_o for the read mux.
// Optional build macro REG0_HARDWIRE_EN: register 0 reads as constant zero and
// writes to it are accepted but discarded.
module regfile_write_bank
  import regfile_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 wr_valid_i,
  output logic                 wr_ready_o,
  input  reg_idx_t             wr_addr_i,
  input  logic [DW-1:0]        wr_data_i,
  input  logic                 clr_req_i,
  output logic                 clr_busy_o,
  output logic                 clr_done_o,
  output logic [NREG*DW-1:0]   q_all_o
);

  wb_state_t       state_q, state_d;
  reg_idx_t        clr_cnt_q, clr_cnt_d;
  logic [DW-1:0]   regs_q [NREG];

  logic            wr_fire;
  reg_idx_t        sel_idx;
  logic            sel_en;
  logic [DW-1:0]   row_data;
  logic [NREG-1:0] row_sel;
  logic [NREG-1:0] row_we;

  // Handshake outputs, next-state logic and row-select source muxing.
  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    wr_ready_o = 1'b0;
    clr_busy_o = 1'b0;
    clr_done_o = 1'b0;
    wr_fire    = 1'b0;
    sel_idx    = wr_addr_i;
    sel_en     = 1'b0;
    row_data   = wr_data_i;
    unique case (state_q)
      ST_IDLE: begin
        wr_ready_o = 1'b1;
        wr_fire    = wr_valid_i;
        sel_en     = wr_fire;
        // A write in the same cycle still lands; the clear reaches it later.
        if (clr_req_i) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
        end
      end
      ST_CLEAR: begin
        clr_busy_o = 1'b1;
        sel_idx    = clr_cnt_q;
        sel_en     = 1'b1;
        row_data   = '0;
        clr_cnt_d  = clr_cnt_q + reg_idx_t'(1);
        if (clr_cnt_q == reg_idx_t'(NREG - 1)) begin
          clr_done_o = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  decoder5_to_32 u_decoder (
    .idx_i    (sel_idx),
    .en_i     (sel_en),
    .onehot_o (row_sel)
  );

  // Register 0 never takes a write when hardwired, so it stays at its reset zero.
  always_comb begin
`ifdef REG0_HARDWIRE_EN
    row_we = {row_sel[NREG-1:1], 1'b0};
`else
    row_we = row_sel;
`endif
  end

  // Sequencer state with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Storage array; unselected rows hold.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (row_we[i]) begin
          regs_q[i] <= row_data;
        end
      end
    end
  end

  // Flatten the array onto the read-mux bus.
  always_comb begin
    q_all_o = '0;
    for (int i = 0; i < NREG; i++) begin
      q_all_o[DW*i +: DW] = regs_q[i];
    end
`ifdef REG0_HARDWIRE_EN
    q_all_o[DW-1:0] = '0;
`endif
  end

endmodule

// File: tb/tb_regfile_write_bank.sv
// Self-checking bench for regfile_write_bank: directed scenarios followed by
// random traffic, all compared against an array-based reference model.
module tb_regfile_write_bank;

  logic          clk;
  logic          rst;
  logic          wr_valid;
  logic          wr_ready;
  logic [4:0]    wr_addr;
  logic [31:0]   wr_data;
  logic          clr_req;
  logic          clr_busy;
  logic          clr_done;
  logic [1023:0] q_all;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model: register contents plus the register the clear will zero
  // next (-1 when no clear is running).
  logic [31:0] m_regs [32];
  int          m_pos;

  regfile_write_bank dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .wr_valid_i (wr_valid),
    .wr_ready_o (wr_ready),
    .wr_addr_i  (wr_addr),
    .wr_data_i  (wr_data),
    .clr_req_i  (clr_req),
    .clr_busy_o (clr_busy),
    .clr_done_o (clr_done),
    .q_all_o    (q_all)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] get_reg(input int i);
    return q_all[32*i +: 32];
  endfunction

  function automatic bit write_lands(input logic [4:0] a);
`ifdef REG0_HARDWIRE_EN
    return a != 5'd0;
`else
    return 1'b1;
`endif
  endfunction

  // One clock cycle: drive inputs, check outputs mid-cycle, advance the model.
  task automatic step(input logic v, input logic [4:0] a, input logic [31:0] d,
                      input logic c, input logic r);
    rst      = r;
    wr_valid = v;
    wr_addr  = a;
    wr_data  = d;
    clr_req  = c;
    @(negedge clk);
    check_eq("wr_ready", 32'(wr_ready), 32'(m_pos < 0));
    check_eq("clr_busy", 32'(clr_busy), 32'(m_pos >= 0));
    check_eq("clr_done", 32'(clr_done), 32'(m_pos == 31));
    for (int i = 0; i < 32; i++) begin
      check_eq($sformatf("reg%0d", i), get_reg(i), m_regs[i]);
    end
    if (r) begin
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_pos = -1;
    end else if (m_pos < 0) begin
      if (v && write_lands(a)) m_regs[a] = d;
      if (c) m_pos = 0;
    end else begin
      m_regs[m_pos] = '0;
      m_pos = (m_pos == 31) ? -1 : m_pos + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; clr_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_pos = -1;
    step(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);  // reset state check

    // 1: single write
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0);
    idle(1);
    check_eq("t1_reg5", get_reg(5), 32'hDEADBEEF);

    // 2: top register and register 0
    step(1'b1, 5'd31, 32'h1234_5678, 1'b0, 1'b0);
    step(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    idle(1);
    check_eq("t2_reg31", get_reg(31), 32'h1234_5678);
`ifdef REG0_HARDWIRE_EN
    check_eq("t2_reg0", get_reg(0), 32'h0);
`else
    check_eq("t2_reg0", get_reg(0), 32'hFFFF_FFFF);
`endif

    // 3: fill then full clear
    for (int i = 0; i < 32; i++) step(1'b1, 5'(i), 32'(i + 1), 1'b0, 1'b0);
    step(1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    for (int k = 0; k < 32; k++) step(1'b0, 5'd0, 32'd0, 1'b1, 1'b0);  // req ignored
    idle(1);
    check_eq("t3_ready", 32'(wr_ready), 32'd1);
    check_eq("t3_reg20", get_reg(20), 32'd0);

    // 4: write and clear request in the same cycle
    step(1'b1, 5'd7, 32'hA5A5_A5A5, 1'b1, 1'b0);
    idle(33);
    check_eq("t4_reg7", get_reg(7), 32'd0);

    // 5: write held through a clear
    step(1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    for (int k = 0; k < 33; k++) step(1'b1, 5'd3, 32'h55, 1'b0, 1'b0);
    idle(1);
    check_eq("t5_reg3", get_reg(3), 32'h55);

    // 6: reset in the middle of a clear
    for (int i = 0; i < 32; i++) step(1'b1, 5'(i), $urandom, 1'b0, 1'b0);
    step(1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    idle(10);
    step(1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    idle(2);
    check_eq("t6_reg31", get_reg(31), 32'd0);

    // Random traffic
    for (int k = 0; k < 600; k++) begin
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
           1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 199) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
